// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared datapath width, ALU opcodes and forwarding selects
// Contents: DPW datapath width, alu_op_t ALU operations, fwd_sel_t operand
// forwarding selects, fwd_mux helper that resolves a forwarding select.
package rv32i_pkg;

    localparam int DPW = 32;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_op_t;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_W   = 2'b01,
        FWD_M   = 2'b10
    } fwd_sel_t;

    // Select 2'b11 is unused by hazard logic and falls back to the register value.
    function automatic logic [DPW-1:0] fwd_mux(
        input logic [1:0]     sel,
        input logic [DPW-1:0] reg_val,
        input logic [DPW-1:0] w_val,
        input logic [DPW-1:0] m_val
    );
        case (sel)
            FWD_W:   fwd_mux = w_val;
            FWD_M:   fwd_mux = m_val;
            default: fwd_mux = reg_val;
        endcase
    endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational execute-stage ALU
// Ports: a, b operands; alu_ctrl operation; result DPW-bit result; zero result==0.
module alu
    import rv32i_pkg::*;
(
    input  logic [DPW-1:0] a,
    input  logic [DPW-1:0] b,
    input  alu_op_t        alu_ctrl,
    output logic [DPW-1:0] result,
    output logic           zero
);

    always_comb begin
        result = '0;
        case (alu_ctrl)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = {{(DPW-1){1'b0}}, ($signed(a) < $signed(b))};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - execute, memory and writeback pipeline stages
// Ports: clk, rst (sync, active-high); E-stage controls, operands, RdE and
// forwarding selects in; zeroE, aluresultM, RdM/RdW, regwriteM/regwriteW for
// hazard logic; we/addr_3/wd_3 drive the register-file write port.
module writeback_stage
    import rv32i_pkg::*;
#(
    parameter int ADW        = 5,
    parameter int DMEM_DEPTH = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           resultsrcE,
    input  logic           memwriteE,
    input  logic           alusrcE,
    input  logic           regwriteE,
    input  alu_op_t        alu_ctrlE,
    input  logic [DPW-1:0] srcA,
    input  logic [DPW-1:0] Rd2E,
    input  logic [DPW-1:0] immextE,
    input  logic [4:0]     RdE,
    input  logic [1:0]     forwardAE,
    input  logic [1:0]     forwardBE,
    output logic           zeroE,
    output logic [DPW-1:0] aluresultM,
    output logic [4:0]     RdM,
    output logic [4:0]     RdW,
    output logic           regwriteM,
    output logic           regwriteW,
    output logic           we,
    output logic [ADW-1:0] addr_3,
    output logic [DPW-1:0] wd_3
);

    localparam int IDXW = $clog2(DMEM_DEPTH);

    logic [DPW-1:0] src_a_fwd;
    logic [DPW-1:0] src_b_fwd;
    logic [DPW-1:0] src_b;
    logic [DPW-1:0] aluresultE;
    logic [DPW-1:0] resultW;

    logic [DPW-1:0] writedataM;
    logic           resultsrcM;
    logic           memwriteM;
    logic [DPW-1:0] readdataM;
    logic [IDXW-1:0] mem_idx;

    logic [DPW-1:0] aluresultW;
    logic [DPW-1:0] readdataW;
    logic           resultsrcW;

    logic [DPW-1:0] dmem [DMEM_DEPTH];

    assign src_a_fwd = fwd_mux(forwardAE, srcA, resultW, aluresultM);
    assign src_b_fwd = fwd_mux(forwardBE, Rd2E, resultW, aluresultM);
    assign src_b     = alusrcE ? immextE : src_b_fwd;

    alu u_alu (
        .a        (src_a_fwd),
        .b        (src_b),
        .alu_ctrl (alu_ctrlE),
        .result   (aluresultE),
        .zero     (zeroE)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            aluresultM <= '0;
            writedataM <= '0;
            RdM        <= '0;
            regwriteM  <= 1'b0;
            resultsrcM <= 1'b0;
            memwriteM  <= 1'b0;
            aluresultW <= '0;
            readdataW  <= '0;
            RdW        <= '0;
            regwriteW  <= 1'b0;
            resultsrcW <= 1'b0;
        end else begin
            aluresultM <= aluresultE;
            writedataM <= src_b_fwd;
            RdM        <= RdE;
            regwriteM  <= regwriteE;
            resultsrcM <= resultsrcE;
            memwriteM  <= memwriteE;
            aluresultW <= aluresultM;
            readdataW  <= readdataM;
            RdW        <= RdM;
            regwriteW  <= regwriteM;
            resultsrcW <= resultsrcM;
        end
    end

    // Word-addressed: byte offset dropped, address bits above the depth wrap.
    assign mem_idx   = aluresultM[IDXW+1:2];
    assign readdataM = dmem[mem_idx];

    // Contents survive reset; reset only blocks the store sitting in M.
    always_ff @(posedge clk) begin
        if (memwriteM && !rst) begin
            dmem[mem_idx] <= writedataM;
        end
    end

    assign resultW = resultsrcW ? readdataW : aluresultW;
    assign wd_3    = resultW;
    assign addr_3  = RdW[ADW-1:0];
    assign we      = regwriteW && (RdW != 5'd0);

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - self-checking bench for writeback_stage
module tb_writeback_stage;
    import rv32i_pkg::*;

    localparam int ADW   = 5;
    localparam int DEPTH = 64;

    logic           clk = 1'b0;
    logic           rst;
    logic           resultsrcE, memwriteE, alusrcE, regwriteE;
    alu_op_t        alu_ctrlE;
    logic [31:0]    srcA, Rd2E, immextE;
    logic [4:0]     RdE;
    logic [1:0]     forwardAE, forwardBE;
    logic           zeroE;
    logic [31:0]    aluresultM;
    logic [4:0]     RdM, RdW;
    logic           regwriteM, regwriteW;
    logic           we;
    logic [ADW-1:0] addr_3;
    logic [31:0]    wd_3;

    always #5 clk = ~clk;

    writeback_stage #(.ADW(ADW), .DMEM_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .resultsrcE (resultsrcE),
        .memwriteE  (memwriteE),
        .alusrcE    (alusrcE),
        .regwriteE  (regwriteE),
        .alu_ctrlE  (alu_ctrlE),
        .srcA       (srcA),
        .Rd2E       (Rd2E),
        .immextE    (immextE),
        .RdE        (RdE),
        .forwardAE  (forwardAE),
        .forwardBE  (forwardBE),
        .zeroE      (zeroE),
        .aluresultM (aluresultM),
        .RdM        (RdM),
        .RdW        (RdW),
        .regwriteM  (regwriteM),
        .regwriteW  (regwriteW),
        .we         (we),
        .addr_3     (addr_3),
        .wd_3       (wd_3)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, rd2, imm;
        logic        alusrc, memwrite, resultsrc, regwrite;
        logic [1:0]  fa, fb;
        logic [4:0]  rd;
    } instr_t;

    // Retired-instruction record: what each earlier instruction produced.
    typedef struct {
        logic [31:0] alu, result;
        logic [4:0]  rd;
        logic        regwrite;
    } done_t;

    done_t       hist[$];
    logic [31:0] mem_m [DEPTH];
    int          errors = 0;
    int          checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic instr_t mk(input logic [2:0] op, input logic [31:0] a, rd2, imm,
                                  input logic alusrc, input logic [1:0] fa, fb,
                                  input logic memwrite, resultsrc, regwrite, input logic [4:0] rd);
        instr_t t;
        t.op = op; t.a = a; t.rd2 = rd2; t.imm = imm; t.alusrc = alusrc;
        t.fa = fa; t.fb = fb; t.memwrite = memwrite; t.resultsrc = resultsrc;
        t.regwrite = regwrite; t.rd = rd;
        return t;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, b);
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_SLT: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf, w, m);
        if (sel == 2'b01) return w;
        if (sel == 2'b10) return m;
        return rf;
    endfunction

    task automatic drive(input instr_t in);
        alu_ctrlE  = alu_op_t'(in.op);
        srcA       = in.a;
        Rd2E       = in.rd2;
        immextE    = in.imm;
        alusrcE    = in.alusrc;
        memwriteE  = in.memwrite;
        resultsrcE = in.resultsrc;
        regwriteE  = in.regwrite;
        forwardAE  = in.fa;
        forwardBE  = in.fb;
        RdE        = in.rd;
    endtask

    function automatic done_t zero_rec();
        done_t z;
        z.alu = '0; z.result = '0; z.rd = '0; z.regwrite = 1'b0;
        return z;
    endfunction

    // Entered and left at a falling edge. Checks the two older instructions now
    // in M and W, presents the new one, and retires it into the model.
    task automatic issue(input instr_t in, input bit apply_mem);
        done_t p1, p2, d;
        logic [31:0] a, b, sb, r;
        int idx;
        p1 = hist[hist.size()-1];
        p2 = hist[hist.size()-2];
        check_eq("aluresultM", aluresultM, p1.alu);
        check_eq("RdM", {27'd0, RdM}, {27'd0, p1.rd});
        check_eq("regwriteM", {31'd0, regwriteM}, {31'd0, p1.regwrite});
        check_eq("RdW", {27'd0, RdW}, {27'd0, p2.rd});
        check_eq("regwriteW", {31'd0, regwriteW}, {31'd0, p2.regwrite});
        check_eq("we", {31'd0, we}, {31'd0, (p2.regwrite && p2.rd != 5'd0)});
        check_eq("addr_3", {27'd0, addr_3}, {27'd0, p2.rd});
        check_eq("wd_3", wd_3, p2.result);
        drive(in);
        a  = pick(in.fa, in.a, p2.result, p1.alu);
        b  = pick(in.fb, in.rd2, p2.result, p1.alu);
        sb = in.alusrc ? in.imm : b;
        r  = ref_alu(in.op, a, sb);
        #1;
        check_eq("zeroE", {31'd0, zeroE}, {31'd0, (r == 32'd0)});
        idx = int'((r >> 2) % DEPTH);
        d.alu = r;
        d.result = in.resultsrc ? mem_m[idx] : r;
        if (in.memwrite && apply_mem) mem_m[idx] = b;
        d.rd = in.rd;
        d.regwrite = in.regwrite;
        hist.push_back(d);
        @(posedge clk);
        @(negedge clk);
    endtask

    instr_t bub;

    initial begin
        bub = mk(3'b000, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 5'd0);
        rst = 1'b1;
        drive(bub);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        hist.push_back(zero_rec());
        hist.push_back(zero_rec());
        check_eq("rst_we", {31'd0, we}, 32'd0);
        check_eq("rst_regwriteW", {31'd0, regwriteW}, 32'd0);
        check_eq("rst_aluresultM", aluresultM, 32'd0);
        check_eq("rst_wd_3", wd_3, 32'd0);

        // Fill every data-memory word with a known pattern.
        for (int i = 0; i < DEPTH; i++)
            issue(mk(ALU_ADD, i * 4, {16'hC0DE, 16'(i)}, 0, 1, 2'b00, 2'b00, 1, 0, 0, 5'd0), 1'b1);

        // ADD 5+7 into x3.
        issue(mk(ALU_ADD, 5, 0, 7, 1, 2'b00, 2'b00, 0, 0, 1, 5'd3), 1'b1);
        issue(bub, 1'b1);
        check_eq("add_we", {31'd0, we}, 32'd1);
        check_eq("add_addr", {27'd0, addr_3}, 32'd3);
        check_eq("add_wd", wd_3, 32'd12);

        // Store then immediate load of the same word.
        issue(mk(ALU_ADD, 32'h10, 32'hDEADBEEF, 4, 1, 2'b00, 2'b00, 1, 0, 0, 5'd0), 1'b1);
        issue(mk(ALU_ADD, 32'h10, 0, 4, 1, 2'b00, 2'b00, 0, 1, 1, 5'd7), 1'b1);
        issue(bub, 1'b1);
        check_eq("ld_wd", wd_3, 32'hDEADBEEF);
        check_eq("ld_addr", {27'd0, addr_3}, 32'd7);

        // Forward from M (12) and from W (9).
        issue(mk(ALU_ADD, 5, 0, 7, 1, 2'b00, 2'b00, 0, 0, 1, 5'd3), 1'b1);
        issue(mk(ALU_SUB, 0, 0, 2, 1, 2'b10, 2'b00, 0, 0, 1, 5'd4), 1'b1);
        check_eq("fwd_m", aluresultM, 32'd10);
        issue(mk(ALU_ADD, 4, 0, 5, 1, 2'b00, 2'b00, 0, 0, 1, 5'd5), 1'b1);
        issue(bub, 1'b1);
        issue(mk(ALU_SUB, 0, 0, 2, 1, 2'b01, 2'b00, 0, 0, 1, 5'd6), 1'b1);
        check_eq("fwd_w", aluresultM, 32'd7);

        // Signed compare and zero flag.
        issue(mk(ALU_SLT, 32'hFFFFFFFF, 0, 1, 1, 2'b00, 2'b00, 0, 0, 1, 5'd8), 1'b1);
        check_eq("slt_neg", aluresultM, 32'd1);
        issue(mk(ALU_SLT, 1, 32'hFFFFFFFF, 0, 0, 2'b00, 2'b00, 0, 0, 1, 5'd9), 1'b1);
        check_eq("slt_pos", aluresultM, 32'd0);
        issue(mk(ALU_SUB, 3, 3, 0, 0, 2'b00, 2'b00, 0, 0, 1, 5'd10), 1'b1);
        check_eq("sub_zero", {31'd0, zeroE}, 32'd1);

        // Reset while a store to word 8 sits in M: store must be dropped.
        issue(mk(ALU_ADD, 32'h20, 32'h12345678, 0, 1, 2'b00, 2'b00, 1, 0, 0, 5'd0), 1'b0);
        rst = 1'b1;
        drive(bub);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        hist.push_back(zero_rec());
        hist.push_back(zero_rec());
        check_eq("midrst_we", {31'd0, we}, 32'd0);
        check_eq("midrst_regwriteM", {31'd0, regwriteM}, 32'd0);
        check_eq("midrst_RdM", {27'd0, RdM}, 32'd0);
        check_eq("midrst_aluresultM", aluresultM, 32'd0);
        issue(mk(ALU_ADD, 32'h20, 0, 0, 1, 2'b00, 2'b00, 0, 1, 1, 5'd11), 1'b1);
        issue(bub, 1'b1);
        check_eq("midrst_mem", wd_3, 32'hC0DE0008);

        // Write to x0 is never issued.
        issue(mk(ALU_ADD, 32'h55, 0, 0, 1, 2'b00, 2'b00, 0, 0, 1, 5'd0), 1'b1);
        issue(bub, 1'b1);
        check_eq("x0_we", {31'd0, we}, 32'd0);
        check_eq("x0_wd", wd_3, 32'h55);

        // Random traffic, including unknown opcodes and select 2'b11.
        for (int n = 0; n < 400; n++) begin
            instr_t t;
            int kind;
            kind = $urandom_range(0, 2);
            t = mk(3'($urandom_range(0, 7)), $urandom, $urandom, $urandom_range(0, 255),
                   1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   kind == 2, kind == 1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
            issue(t, 1'b1);
        end
        issue(bub, 1'b1);
        issue(bub, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
